// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and EX operand forwarding.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W     = 4,
    parameter int LOAD_USE_STALL = 1,
    parameter int ZERO_REG_EN    = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  fd_write,
    output logic                  de_bubble,
    output logic                  flush_fd,
    output logic                  flush_de,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_events
`endif
);

    typedef logic [REG_ADDR_W-1:0] reg_t;

    typedef struct packed {
        logic valid;
        reg_t rd;
        logic regwrite;
        logic memread;
    } ent_t;

    // Counter reload: the detecting cycle is the first bubble.
    localparam logic [1:0] SCNT_LOAD = 2'(LOAD_USE_STALL - 1);

    ent_t       ex_q;
    ent_t       mem_q;
    logic       wb_valid_q;
    logic       wb_regwrite_q;
    reg_t       wb_rd_q;
    reg_t       ex_rs1_q;
    reg_t       ex_rs2_q;
    logic       ex_rs1_used_q;
    logic       ex_rs2_used_q;
    logic [1:0] scnt_q;
    logic       rst_q;

    logic ex_live;
    logic mem_live;
    logic wb_live;
    logic hazard;
    logic in_rst;
    logic branch;
    logic stall;

    function automatic logic live(logic v, logic rw, reg_t rd);
        return v & rw & ~((ZERO_REG_EN != 0) && (rd == '0));
    endfunction

    // Hazard detection and stall/branch arbitration.
    always_comb begin
        ex_live  = live(ex_q.valid, ex_q.regwrite, ex_q.rd);
        mem_live = live(mem_q.valid, mem_q.regwrite, mem_q.rd);
        wb_live  = live(wb_valid_q, wb_regwrite_q, wb_rd_q);
        hazard   = ex_live & ex_q.memread & id_valid &
                   ((id_rs1_used & (id_rs1 == ex_q.rd)) |
                    (id_rs2_used & (id_rs2 == ex_q.rd)));
        in_rst   = rst | rst_q;
        branch   = ex_branch_taken & ~in_rst;
        stall    = ~in_rst & ~branch & (hazard | (scnt_q != 2'd0));
    end

    assign pc_write  = ~stall;
    assign fd_write  = ~stall;
    assign de_bubble = stall;
    assign flush_fd  = branch;
    assign flush_de  = branch;

    // Forwarding selects; MEM wins over WB, loads in MEM never forward.
    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (!in_rst) begin
            if (ex_rs1_used_q && mem_live && !mem_q.memread &&
                mem_q.rd == ex_rs1_q) begin
                fwd_a_sel = 2'd1;
            end else if (ex_rs1_used_q && wb_live && wb_rd_q == ex_rs1_q) begin
                fwd_a_sel = 2'd2;
            end
            if (ex_rs2_used_q && mem_live && !mem_q.memread &&
                mem_q.rd == ex_rs2_q) begin
                fwd_b_sel = 2'd1;
            end else if (ex_rs2_used_q && wb_live && wb_rd_q == ex_rs2_q) begin
                fwd_b_sel = 2'd2;
            end
        end
    end

    // Scoreboard shift and stall counter.
    always_ff @(posedge clock) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            scnt_q        <= 2'd0;
            rst_q         <= 1'b1;
        end else begin
            rst_q         <= 1'b0;
            mem_q         <= ex_q;
            wb_valid_q    <= mem_q.valid;
            wb_regwrite_q <= mem_q.regwrite;
            wb_rd_q       <= mem_q.rd;
            if (branch || stall) begin
                ex_q          <= '0;
                ex_rs1_q      <= '0;
                ex_rs2_q      <= '0;
                ex_rs1_used_q <= 1'b0;
                ex_rs2_used_q <= 1'b0;
            end else begin
                ex_q          <= '{valid: id_valid, rd: id_rd,
                                   regwrite: id_regwrite,
                                   memread: id_memread};
                ex_rs1_q      <= id_rs1;
                ex_rs2_q      <= id_rs2;
                ex_rs1_used_q <= id_rs1_used;
                ex_rs2_used_q <= id_rs2_used;
            end
            if (stall) begin
                scnt_q <= (scnt_q == 2'd0) ? SCNT_LOAD : scnt_q - 2'd1;
            end else begin
                scnt_q <= 2'd0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating stall / flush event counters.
    always_ff @(posedge clock) begin
        if (rst) begin
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            if (!pc_write && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (flush_fd && flush_events != 16'hFFFF) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random checks of two controllers
// (stall depth 1 and 2) against a behavioural pipeline model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] id_rs1 = 4'd0;
    logic [3:0] id_rs2 = 4'd0;
    logic [3:0] id_rd = 4'd0;
    logic       id_rs1_used = 1'b0;
    logic       id_rs2_used = 1'b0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       ex_branch_taken = 1'b0;

    logic       pc_w [2];
    logic       fd_w [2];
    logic       bub  [2];
    logic       ffd  [2];
    logic       fde  [2];
    logic [1:0] fa   [2];
    logic [1:0] fb   [2];
`ifdef HAZARD_PERF_EN
    logic [15:0] sc [2];
    logic [15:0] fe [2];
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(4), .LOAD_USE_STALL(1), .ZERO_REG_EN(1)
    ) dut1 (
        .clock(clock), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_w[0]), .fd_write(fd_w[0]), .de_bubble(bub[0]),
        .flush_fd(ffd[0]), .flush_de(fde[0]),
        .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc[0]), .flush_events(fe[0])
`endif
    );

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(4), .LOAD_USE_STALL(2), .ZERO_REG_EN(1)
    ) dut2 (
        .clock(clock), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_w[1]), .fd_write(fd_w[1]), .de_bubble(bub[1]),
        .flush_fd(ffd[1]), .flush_de(fde[1]),
        .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc[1]), .flush_events(fe[1])
`endif
    );

    // Behavioural model: each pipe slot holds a whole instruction.
    typedef struct {
        bit v;
        int rd;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        bit rw;
        bit mr;
    } ins_t;

    ins_t pe [2][3];
    int   owe [2];
    bit   post [2];
    int   depth [2] = '{1, 2};
    int   exp_sc [2];
    int   exp_fe [2];
    bit   mvalid = 1'b0;

    function automatic bit writes(ins_t i);
        return i.v && i.rw && i.rd != 0;
    endfunction

    function automatic bit reads(ins_t c, int r);
        return c.v && ((c.u1 && c.rs1 == r) || (c.u2 && c.rs2 == r));
    endfunction

    function automatic int src(bit used, int r, ins_t m, ins_t w);
        if (!used) return 0;
        if (writes(m) && !m.mr && m.rd == r) return 1;
        if (writes(w) && w.rd == r) return 2;
        return 0;
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%0d exp=%0d",
                     nm, k + 1, $time, act, exp);
        end
    endtask

    // Per-cycle compare of both DUTs against the model.
    always @(negedge clock) begin : cmp
        ins_t cur;
        ins_t nop;
        bit   br;
        bit   haz;
        bit   st;
        int   e_fa;
        int   e_fb;
        nop = '{default: 0};
        cur.v   = id_valid;
        cur.rd  = int'(id_rd);
        cur.rs1 = int'(id_rs1);
        cur.rs2 = int'(id_rs2);
        cur.u1  = id_rs1_used;
        cur.u2  = id_rs2_used;
        cur.rw  = id_regwrite;
        cur.mr  = id_memread;
        for (int k = 0; k < 2; k++) begin
            br = 1'b0; st = 1'b0; e_fa = 0; e_fb = 0;
            if (!(rst || post[k])) begin
                br   = ex_branch_taken;
                haz  = pe[k][0].mr && writes(pe[k][0]) &&
                       reads(cur, pe[k][0].rd);
                st   = !br && (haz || owe[k] > 0);
                e_fa = src(pe[k][0].u1, pe[k][0].rs1, pe[k][1], pe[k][2]);
                e_fb = src(pe[k][0].u2, pe[k][0].rs2, pe[k][1], pe[k][2]);
            end
            if (mvalid || rst) begin
                chk("pc_write", k, 16'(pc_w[k]), 16'(!st));
                chk("fd_write", k, 16'(fd_w[k]), 16'(!st));
                chk("de_bubble", k, 16'(bub[k]), 16'(st));
                chk("flush_fd", k, 16'(ffd[k]), 16'(br));
                chk("flush_de", k, 16'(fde[k]), 16'(br));
                chk("fwd_a_sel", k, 16'(fa[k]), 16'(e_fa));
                chk("fwd_b_sel", k, 16'(fb[k]), 16'(e_fb));
            end
`ifdef HAZARD_PERF_EN
            if (mvalid) begin
                chk("stall_cycles", k, sc[k], 16'(exp_sc[k]));
                chk("flush_events", k, fe[k], 16'(exp_fe[k]));
            end
`endif
            if (rst) begin
                for (int s = 0; s < 3; s++) pe[k][s] = nop;
                owe[k] = 0;
                post[k] = 1'b1;
                exp_sc[k] = 0;
                exp_fe[k] = 0;
            end else begin
                post[k] = 1'b0;
                if (st && exp_sc[k] < 65535) exp_sc[k]++;
                if (br && exp_fe[k] < 65535) exp_fe[k]++;
                pe[k][2] = pe[k][1];
                pe[k][1] = pe[k][0];
                pe[k][0] = (br || st) ? nop : cur;
                if (br) begin
                    owe[k] = 0;
                end else if (st) begin
                    if (owe[k] == 0) owe[k] = depth[k];
                    owe[k]--;
                end
            end
        end
        if (rst) mvalid = 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1,
                         input int rs2, input bit u2, input int rd,
                         input bit rw, input bit mr);
        id_valid    = v;
        id_rs1      = 4'(rs1);
        id_rs1_used = u1;
        id_rs2      = 4'(rs2);
        id_rs2_used = u2;
        id_rd       = 4'(rd);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int nstall [2];

    initial begin
        // Reset, then the first cycle after it.
        rst = 1'b1; idle();
        tick(); tick();
        rst = 1'b0; idle(); #5;
        for (int k = 0; k < 2; k++) begin
            chk("rst_pc_write", k, 16'(pc_w[k]), 16'd1);
            chk("rst_fd_write", k, 16'(fd_w[k]), 16'd1);
            chk("rst_flush", k, 16'(ffd[k] | fde[k]), 16'd0);
            chk("rst_fwd", k, 16'({fa[k], fb[k]}), 16'd0);
        end

        // ALU back-to-back: EX/MEM then MEM/WB forwarding.
        tick(); drive(1, 0, 0, 0, 0, 3, 1, 0);
        tick(); drive(1, 3, 1, 0, 0, 4, 1, 0);
        tick(); drive(1, 3, 1, 0, 0, 5, 1, 0); #5;
        for (int k = 0; k < 2; k++) chk("alu_fwd_mem", k, 16'(fa[k]), 16'd1);
        tick(); idle(); #5;
        for (int k = 0; k < 2; k++) chk("alu_fwd_wb", k, 16'(fa[k]), 16'd2);

        // Load-use with the consumer held in ID.
        tick(); drive(1, 1, 1, 0, 0, 5, 1, 1);
        tick(); drive(1, 1, 1, 5, 1, 7, 1, 0);
        nstall[0] = 0; nstall[1] = 0;
        for (int c = 0; c < 4; c++) begin
            #5;
            for (int k = 0; k < 2; k++) if (!pc_w[k]) nstall[k]++;
            if (c == 0) begin
                for (int k = 0; k < 2; k++)
                    chk("lu_bubble", k, 16'(bub[k]), 16'd1);
            end
            if (c == 2) chk("lu_fwd_b", 0, 16'(fb[0]), 16'd2);
            tick();
        end
        chk("lu_stall_len", 0, 16'(nstall[0]), 16'd1);
        chk("lu_stall_len", 1, 16'(nstall[1]), 16'd2);
        idle(); tick(); tick();

        // Branch during counter-driven stall of the depth-2 unit.
        drive(1, 1, 1, 0, 0, 5, 1, 1);
        tick(); drive(1, 1, 1, 5, 1, 7, 1, 0);
        tick(); ex_branch_taken = 1'b1; #5;
        chk("br_pc_write", 1, 16'(pc_w[1]), 16'd1);
        chk("br_bubble", 1, 16'(bub[1]), 16'd0);
        for (int k = 0; k < 2; k++)
            chk("br_flush", k, 16'({ffd[k], fde[k]}), 16'd3);
        tick(); ex_branch_taken = 1'b0; idle(); #5;
        for (int k = 0; k < 2; k++)
            chk("br_after", k, 16'(pc_w[k]), 16'd1);

        // Branch in the same cycle the hazard is detected.
        tick(); drive(1, 1, 1, 0, 0, 5, 1, 1);
        tick(); drive(1, 1, 1, 5, 1, 7, 1, 0); ex_branch_taken = 1'b1; #5;
        for (int k = 0; k < 2; k++) begin
            chk("brh_pc_write", k, 16'(pc_w[k]), 16'd1);
            chk("brh_flush", k, 16'(ffd[k]), 16'd1);
        end
        tick(); ex_branch_taken = 1'b0; idle(); #5;
        for (int k = 0; k < 2; k++)
            chk("brh_after", k, 16'(pc_w[k]), 16'd1);

        // Register 0: no stall behind a load, no forward from an ALU op.
        tick(); drive(1, 1, 1, 0, 0, 0, 1, 1);
        tick(); drive(1, 0, 1, 0, 1, 8, 1, 0); #5;
        for (int k = 0; k < 2; k++) chk("zr_stall", k, 16'(pc_w[k]), 16'd1);
        tick(); drive(1, 1, 1, 0, 0, 0, 1, 0);
        tick(); drive(1, 0, 1, 2, 0, 9, 1, 0);
        tick(); idle(); #5;
        for (int k = 0; k < 2; k++) chk("zr_fwd", k, 16'(fa[k]), 16'd0);

`ifdef HAZARD_PERF_EN
        // Three load-use stalls and two taken branches.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; idle();
        for (int n = 0; n < 3; n++) begin
            tick(); drive(1, 1, 1, 0, 0, 5, 1, 1);
            tick(); drive(1, 1, 1, 5, 1, 7, 1, 0);
            tick(); idle();
            tick(); tick();
        end
        for (int n = 0; n < 2; n++) begin
            tick(); ex_branch_taken = 1'b1;
            tick(); ex_branch_taken = 1'b0;
        end
        tick(); #5;
        chk("perf_stalls", 0, sc[0], 16'd3);
        chk("perf_stalls", 1, sc[1], 16'd6);
        for (int k = 0; k < 2; k++) chk("perf_flushes", k, fe[k], 16'd2);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; #5;
        for (int k = 0; k < 2; k++)
            chk("perf_clear", k, sc[k] | fe[k], 16'd0);
`endif

        // Random traffic on a small register set.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
        end
        tick(); rst = 1'b0; idle(); ex_branch_taken = 1'b0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
